// File: rtl/bus_dest_writer.sv
// Destination side of the datapath bus: decodes dest_sel into one load enable and holds R0-R15, HI, LO, PC, MDR, MAR, IR, outPort.
// Optional trace outputs (last_dest, last_data, wr_count) are built when BUS_DEST_WRITER_TRACE_EN is defined.
module bus_dest_writer #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] PC_STEP  = 1,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter bit               R0_ZERO  = 1'b1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] BUS_data,
  input  logic [4:0]       dest_sel,
  input  logic             dest_valid,
  input  logic             pc_inc,
  input  logic             mdr_read,
  input  logic             mdr_load,
  input  logic [WIDTH-1:0] mem_data_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] r0_out,
  output logic [WIDTH-1:0] r1_out,
  output logic [WIDTH-1:0] r2_out,
  output logic [WIDTH-1:0] r3_out,
  output logic [WIDTH-1:0] r4_out,
  output logic [WIDTH-1:0] r5_out,
  output logic [WIDTH-1:0] r6_out,
  output logic [WIDTH-1:0] r7_out,
  output logic [WIDTH-1:0] r8_out,
  output logic [WIDTH-1:0] r9_out,
  output logic [WIDTH-1:0] r10_out,
  output logic [WIDTH-1:0] r11_out,
  output logic [WIDTH-1:0] r12_out,
  output logic [WIDTH-1:0] r13_out,
  output logic [WIDTH-1:0] r14_out,
  output logic [WIDTH-1:0] r15_out,
  output logic [WIDTH-1:0] HI_out,
  output logic [WIDTH-1:0] LO_out,
  output logic [WIDTH-1:0] PC_out,
  output logic [WIDTH-1:0] MDR_out,
  output logic [WIDTH-1:0] MAR_out,
  output logic [WIDTH-1:0] IR_out,
  output logic [WIDTH-1:0] outPort_out,
`ifdef BUS_DEST_WRITER_TRACE_EN
  output logic [4:0]       last_dest,
  output logic [WIDTH-1:0] last_data,
  output logic [15:0]      wr_count,
`endif
  output logic             wr_err
);

  logic [15:0]      en_gpr;
  logic             en_hi, en_lo, en_pc, en_mdr, en_outport, en_mar, en_ir;
  logic             rsvd_hit;
  logic [WIDTH-1:0] gpr [16];
  logic [WIDTH-1:0] hi_q, lo_q, pc_q, mdr_q, mar_q, ir_q, outport_q;
  logic             err_q;

  function automatic logic [WIDTH-1:0] pc_advance(input logic [WIDTH-1:0] pc);
    // Plain truncation gives the modulo-2^WIDTH wrap.
    return pc + PC_STEP;
  endfunction

  always_comb begin
    en_gpr     = '0;
    en_hi      = 1'b0;
    en_lo      = 1'b0;
    en_pc      = 1'b0;
    en_mdr     = 1'b0;
    en_outport = 1'b0;
    en_mar     = 1'b0;
    en_ir      = 1'b0;
    rsvd_hit   = 1'b0;
    if (dest_valid) begin
      if (dest_sel < 5'd16) begin
        en_gpr[dest_sel[3:0]] = 1'b1;
      end else begin
        case (dest_sel)
          5'd16:   en_hi      = 1'b1;
          5'd17:   en_lo      = 1'b1;
          5'd20:   en_pc      = 1'b1;
          5'd21:   en_mdr     = 1'b1;
          5'd22:   en_outport = 1'b1;
          5'd23:   en_mar     = 1'b1;
          5'd24:   en_ir      = 1'b1;
          // 18/19 belong to ZHI/ZLOW, which only the ALU writes.
          default: rsvd_hit   = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      for (int i = 0; i < 16; i++) gpr[i] <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      outport_q <= '0;
      mar_q     <= '0;
      ir_q      <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (en_gpr[i] && !(i == 0 && R0_ZERO)) gpr[i] <= BUS_data;
      end
      if (en_hi)      hi_q      <= BUS_data;
      if (en_lo)      lo_q      <= BUS_data;
      if (en_outport) outport_q <= BUS_data;
      if (en_mar)     mar_q     <= BUS_data;
      if (en_ir)      ir_q      <= BUS_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      pc_q <= RESET_PC;
    end else if (en_pc) begin
      pc_q <= BUS_data;
    end else if (pc_inc) begin
      pc_q <= pc_advance(pc_q);
    end
  end

  // A bus write to MDR while mdr_read is high still takes memory data.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      mdr_q <= '0;
    end else if (en_mdr) begin
      mdr_q <= mdr_read ? mem_data_in : BUS_data;
    end else if (mdr_read && mdr_load) begin
      mdr_q <= mem_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      err_q <= 1'b0;
    end else if (rsvd_hit) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

`ifdef BUS_DEST_WRITER_TRACE_EN
  logic             wr_accept;
  logic [WIDTH-1:0] stored_data;
  logic [4:0]       last_dest_q;
  logic [WIDTH-1:0] last_data_q;
  logic [15:0]      wr_count_q;

  always_comb begin
    wr_accept   = dest_valid && !rsvd_hit;
    stored_data = BUS_data;
    if (en_gpr[0] && R0_ZERO) stored_data = '0;
    else if (en_mdr && mdr_read) stored_data = mem_data_in;
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      last_dest_q <= '0;
      last_data_q <= '0;
      wr_count_q  <= '0;
    end else if (wr_accept) begin
      last_dest_q <= dest_sel;
      last_data_q <= stored_data;
      wr_count_q  <= wr_count_q + 16'd1;
    end
  end

  assign last_dest = last_dest_q;
  assign last_data = last_data_q;
  assign wr_count  = wr_count_q;
`endif

  assign r0_out      = R0_ZERO ? '0 : gpr[0];
  assign r1_out      = gpr[1];
  assign r2_out      = gpr[2];
  assign r3_out      = gpr[3];
  assign r4_out      = gpr[4];
  assign r5_out      = gpr[5];
  assign r6_out      = gpr[6];
  assign r7_out      = gpr[7];
  assign r8_out      = gpr[8];
  assign r9_out      = gpr[9];
  assign r10_out     = gpr[10];
  assign r11_out     = gpr[11];
  assign r12_out     = gpr[12];
  assign r13_out     = gpr[13];
  assign r14_out     = gpr[14];
  assign r15_out     = gpr[15];
  assign HI_out      = hi_q;
  assign LO_out      = lo_q;
  assign PC_out      = pc_q;
  assign MDR_out     = mdr_q;
  assign MAR_out     = mar_q;
  assign IR_out      = ir_q;
  assign outPort_out = outport_q;
  assign wr_err      = err_q;

endmodule
